// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, response cause, FSM state.
`include "constants.sv"

package lsu_pkg;
    localparam int unsigned XLEN = `XLEN;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_OK         = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_RANGE      = 2'b10
    } cause_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_cause;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_cause
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_cause
    );
endinterface

// File: rtl/constants.sv
// Machine-wide constants shared by the datapath blocks.
`ifndef CONSTANTS_SV
`define CONSTANTS_SV
`define XLEN 64
`endif

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and store merging
// of a sub-doubleword value into the existing memory doubleword.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_offset,
    input  size_e           i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_store_data
);

    function automatic logic [XLEN-1:0] load_extract(logic [XLEN-1:0] rdata, logic [2:0] off,
                                                     size_e sz, logic uns);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = rdata >> {off, 3'b000};
        case (sz)
            SIZE_B:  res = {{(XLEN-8){lane[7] & ~uns}}, lane[7:0]};
            SIZE_H:  res = {{(XLEN-16){lane[15] & ~uns}}, lane[15:0]};
            SIZE_W:  res = {{(XLEN-32){lane[31] & ~uns}}, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    function automatic logic [XLEN-1:0] store_merge(logic [XLEN-1:0] old, logic [XLEN-1:0] wdata,
                                                    logic [2:0] off, size_e sz);
        logic [7:0]      bmask;
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] res;
        case (sz)
            SIZE_B:  bmask = 8'h01;
            SIZE_H:  bmask = 8'h03;
            SIZE_W:  bmask = 8'h0F;
            default: bmask = 8'hFF;
        endcase
        // Accesses are aligned, so the shifted mask never wraps past byte 7.
        bmask   = bmask << off;
        shifted = wdata << {off, 3'b000};
        res     = old;
        for (int i = 0; i < 8; i++) begin
            if (bmask[i]) res[i*8 +: 8] = shifted[i*8 +: 8];
        end
        return res;
    endfunction

    assign o_load_data  = load_extract(i_rdata, i_offset, i_size, i_unsigned);
    assign o_store_data = store_merge(i_rdata, i_wdata, i_offset, i_size);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of the doubleword data memory: alignment and range checks,
// load extension, read-modify-write stores, one request outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_we;
    size_e           r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    cause_e          r_cause;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    logic            w_accept;
    logic [2:0]      w_align_mask;
    logic            w_misaligned;
    logic            w_out_of_range;
    logic            w_in_access;
    logic [XLEN-1:0] w_access_addr;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_store_data;

    assign w_accept = (r_state == StIdle) && bus.req_valid;

    always_comb begin
        case (size_e'(bus.req_size))
            SIZE_B:  w_align_mask = 3'b000;
            SIZE_H:  w_align_mask = 3'b001;
            SIZE_W:  w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_misaligned   = (bus.req_addr[2:0] & w_align_mask) != 3'b000;
    assign w_out_of_range = (bus.req_addr >> ADDR_BITS) != '0;

    assign w_in_access   = (r_state == StAccess);
    assign w_access_addr = {r_addr[XLEN-1:3], 3'b000};

    lsu_lane_align u_lane_align (
        .i_rdata      (i_mem_rdata),
        .i_wdata      (r_wdata),
        .i_offset     (r_addr[2:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = (w_misaligned || w_out_of_range) ? StResp : StAccess;
            end
            StAccess: w_state_next = StResp;
            StResp:   if (bus.resp_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_size      <= SIZE_B;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cause     <= CAUSE_OK;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= size_e'(bus.req_size);
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_rdata    <= '0;
                if (w_misaligned)        r_cause <= CAUSE_MISALIGNED;
                else if (w_out_of_range) r_cause <= CAUSE_RANGE;
                else                     r_cause <= CAUSE_OK;
            end
            if (w_in_access) begin
                r_mem_addr <= w_access_addr;
                if (r_we) r_mem_wdata <= w_store_data;
                else      r_rdata     <= w_load_data;
            end
        end
    end

    // Memory controls are driven live during ACCESS so the combinational read and the
    // write both see the current request; mem_we stays a pure decode of the state.
    assign o_mem_we    = w_in_access && r_we;
    assign o_mem_addr  = w_in_access ? w_access_addr : r_mem_addr;
    assign o_mem_wdata = (w_in_access && r_we) ? w_store_data : r_mem_wdata;

    assign bus.req_ready  = (r_state == StIdle);
    assign bus.resp_valid = (r_state == StResp);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_cause = r_cause;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the doubleword data memory (XLEN=64, combinational read, write on posedge when mem_we).
- Accepts byte/half/word/doubleword load and store requests from the execute stage.
- Performs alignment and range checks; does sign/zero extension for loads and read-modify-write merging for sub-doubleword stores.
- Presents responses via a valid/ready handshake; one request outstanding at a time.

Parameters:
- ADDR_BITS, 16, byte-address width of the attached data memory; must match the memory's ADDR_BITS, minimum 4.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores and doublewords.
- req_addr  in  `XLEN  byte address.
- req_wdata  in  `XLEN  store data, right-aligned (bits [8·2^size-1:0] used).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  `XLEN  extended load data; 0 for stores and errors.
- resp_cause  out  2  00 ok, 01 misaligned, 10 out of range.
- mem_addr  out  `XLEN  to memory addr.
- mem_we  out  1  to memory we.
- mem_wdata  out  `XLEN  to memory input_data.
- mem_rdata  in  `XLEN  from memory output_data.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_cause=00, mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we is decoded from the state register, so assertion of rst_n=0 drops it immediately, without waiting for a clock edge.
- req_ready=1 only in IDLE. Accept happens on a posedge with req_valid && req_ready; the unit latches we, size, unsigned, addr and wdata.
- Checks at accept, misaligned has priority:
  - misaligned: addr mod 2^size ≠ 0;
  - out of range: addr[XLEN-1:ADDR_BITS] ≠ 0.
  - On error: IDLE→RESP directly, cause set, resp_rdata=0, no memory write. Latency 1 cycle.
- IDLE→ACCESS on an accepted request that passes both checks.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr with bits [2:0] cleared.
  - offset = addr[2:0]·8.
  - Load: lane = mem_rdata >> offset, truncated to the size, then sign- or zero-extended. Registered into resp_rdata at the posedge; →RESP.
  - Store: mem_wdata = mem_rdata with byte lanes [addr[2:0], addr[2:0]+2^size-1] replaced by the low bytes of wdata; all other bytes unchanged. mem_we=1 this cycle only; →RESP with resp_rdata=0, cause=00.
- Outside ACCESS: mem_we=0; mem_addr and mem_wdata hold their last values.
- Latency: response valid 2 cycles after accept for valid accesses, 1 cycle for errors.
- RESP: resp_valid=1; resp_rdata and resp_cause are stable until the handshake. →IDLE on the posedge with resp_ready=1. No new request is accepted in the same cycle (no bypass).
- Reset mid-operation (ACCESS or RESP): →IDLE, outputs take their reset values, the pending response is discarded, and no write completes if reset is asserted before the ACCESS posedge.
- The unit uses no state beyond the FSM and the latched request/response registers.

Decomposition:
- Shared package lsu_pkg holds:
  - size enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D);
  - cause enum (CAUSE_OK, CAUSE_MISALIGNED, CAUSE_RANGE);
  - state enum.
- `XLEN comes from constants.sv.
- One natural sub-module, lsu_lane_align (combinational), with:
  - a load-extract/extend function: mem_rdata, offset, size, unsigned → data;
  - a store-merge function: old, wdata, offset, size → merged.
- The FSM and registers live in load_store_unit.

Test Plan:
- Memory word@0x10 = 0x8877665544332211; load byte addr 0x17 signed → resp_rdata 0xFFFFFFFFFFFFFF88 two cycles after accept; unsigned → 0x0000000000000088.
- Store half 0xBEEF @0x12 over 0x8877665544332211 → mem_we for exactly one cycle, word becomes 0x88776655BEEF2211; a follow-up doubleword load returns that value.
- Load word @0x16 → resp_cause 01 one cycle after accept, mem_we never asserted, memory unchanged.
- ADDR_BITS=16, store doubleword @0x10000 → resp_cause 10, no write.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_cause stable, req_ready=0; release → IDLE next cycle, new request accepted the cycle after.
- Assert rst_n=0 during ACCESS of a store → mem_we drops immediately, memory unchanged, resp_valid=0, req_ready=1 after reset release.
